id_issue_ctrl: RTL and testbench
================================

// Module: id_issue_ctrl
// PURPOSE
//  Sequences the instruction-decode stage: buffers fetched instructions in a 2-entry
//  skid queue, presents the head to the combinational decoder, and issues it to EX.
//  Inserts load-use bubbles from the decoder's reg_s/reg_t and flushes on redirect.
//  Sits between the IF stage and the decoder/ID-EX pipeline register.
// PARAMETERS
//  INST_W          32  instruction width
//  ADDR_W          32  PC width
//  LOAD_USE_BUBBLE 1   bubble cycles per detected load-use hazard (1..3)
// PORTS
//  clk            in   1       clock
//  rst            in   1       synchronous, active-high reset
//  if_valid       in   1       IF offers if_inst/if_pc
//  if_inst        in   INST_W  fetched instruction
//  if_pc          in   ADDR_W  PC of if_inst
//  if_ready       out  1       queue can accept (registered)
//  id_valid       out  1       head instruction issuable this cycle
//  id_inst        out  INST_W  head instruction, to decoder
//  id_pc          out  ADDR_W  head PC
//  ex_ready       in   1       EX accepts; issue = id_valid & ex_ready
//  dec_reg_s      in   5       decoder reg_s of head
//  dec_reg_t      in   5       decoder reg_t of head
//  ex_load_valid  in   1       instruction now in EX is a load
//  ex_load_rt     in   5       destination of that load
//  flush          in   1       pipeline redirect; kill all queued instructions
//  stall_cycles   out  32      [ID_PERF_CNT_EN only] cycles head present but not issued
// BEHAVIOUR
//  - Reset: state EMPTY, id_valid 0, id_inst 0, id_pc 0, if_ready 0 during rst,
//    1 first cycle after; bubble counter 0; stall_cycles 0. Mid-op rst drops queue.
//  - FSM on occupancy: EMPTY -> ONE (push) ; ONE -> TWO (push, no pop);
//    ONE -> EMPTY (pop, no push); ONE stays (push+pop or idle); TWO -> ONE (pop);
//    TWO ignores if_valid (if_ready=0). push = if_valid & if_ready.
//  - if_ready registered: next-state != TWO, or next-state == TWO with pop this cycle? No:
//    if_ready(next) = (next_state != TWO). Never accepts into a full queue.
//  - Latency: push at cycle N into EMPTY -> id_inst/id_pc valid at N+1. Order FIFO.
//  - Hazard: haz = ex_load_valid & ex_load_rt!=0 & (ex_load_rt==dec_reg_s |
//    ex_load_rt==dec_reg_t) & state!=EMPTY & bub_cnt==0. On haz: bub_cnt <=
//    LOAD_USE_BUBBLE, id_valid 0 that cycle. While bub_cnt!=0: id_valid 0, decrement.
//    Hazard re-evaluated when bub_cnt reaches 0.
//  - id_valid = state!=EMPTY & bub_cnt==0 & !haz & !flush. Head held stable while
//    id_valid & !ex_ready (no change to id_inst/id_pc).
//  - Flush highest priority: next cycle state EMPTY, bub_cnt 0, id_valid 0;
//    same-cycle if_valid beat is dropped; pop suppressed; if_ready 1 next cycle.
//  - No internal arithmetic beyond 2-bit bub_cnt; stall_cycles wraps at 2^32.
// CONFIGURATION
//  ID_PERF_CNT_EN defined: stall_cycles increments each cycle state!=EMPTY & !issue
//    & !flush; cleared by rst only.
//  Not defined: stall_cycles port absent, no counter logic.
// STRUCTURE
//  defs.v: `IDQ_EMPTY/`IDQ_ONE/`IDQ_TWO state encodings (2 bits), `REG_ZERO 5'd0.
//  Sub-module id_skid_buf: 2-entry inst/pc storage with push/pop/flush and occupancy
//  state; id_issue_ctrl adds hazard bubble counter, issue gating, perf counter.
// TESTING
//  1 rst 3 cycles then push 0x24010005@pc 0xBFC00000, ex_ready=1 -> id_valid=1
//    next cycle with id_inst=0x24010005, id_pc=0xBFC00000; queue EMPTY after issue.
//  2 ex_ready=0, push 3 insts back-to-back -> 2 accepted, if_ready=0 after second,
//    third held by IF; ex_ready=1 -> issued in order, third accepted when slot frees.
//  3 ex_load_valid=1, ex_load_rt=5, dec_reg_t=5, LOAD_USE_BUBBLE=1 -> id_valid=0
//    exactly 2 cycles (detect + 1 bubble) with ex_load_valid dropped after, then issue.
//  4 ex_load_rt=0 with dec_reg_s=0 -> no bubble, issue same cycle.
//  5 queue TWO, flush=1 with if_valid=1 -> next cycle id_valid=0, state EMPTY,
//    if_ready=1, flushed/dropped insts never appear on id_inst with id_valid.
//  6 ID_PERF_CNT_EN: 4 cycles ex_ready=0 with head present -> stall_cycles=4;
//    rst mid-stream -> stall_cycles=0, id_valid=0 next cycle.

Source files
------------

// File: rtl/id_issue_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// id_issue_ctrl_pkg
// Shared definitions for the instruction-decode issue controller:
//   - idq_state_e : occupancy encoding of the 2-entry ID skid queue
//   - REG_ZERO    : architectural zero register (never a hazard source)
//   - load_dep    : true when an in-flight load writes a given source register
// -----------------------------------------------------------------------------
package id_issue_ctrl_pkg;

    typedef enum logic [1:0] {
        IDQ_EMPTY = 2'd0,
        IDQ_ONE   = 2'd1,
        IDQ_TWO   = 2'd2
    } idq_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // A load into r0 never creates a dependency: r0 reads as zero regardless.
    function automatic logic load_dep(input logic [4:0] load_rt, input logic [4:0] src);
        return (load_rt != REG_ZERO) && (load_rt == src);
    endfunction

endpackage

// File: rtl/id_skid_buf.sv
// -----------------------------------------------------------------------------
// id_skid_buf
// Two-entry FIFO holding fetched instruction/PC pairs for the decode stage.
// Entry 0 is always the head; entry 1 only holds data in the TWO state.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   push             write in_inst/in_pc this cycle (caller guarantees not full)
//   pop              retire the head this cycle (caller guarantees not empty)
//   flush            drop all contents; wins over push and pop
//   in_inst, in_pc   incoming instruction / PC
//   head_inst/pc     current head entry
//   state            occupancy (idq_state_e encoding)
//   if_ready         queue will accept a push this cycle
// -----------------------------------------------------------------------------
module id_skid_buf
    import id_issue_ctrl_pkg::*;
#(
    parameter int INST_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [INST_W-1:0] in_inst,
    input  logic [ADDR_W-1:0] in_pc,
    output logic [INST_W-1:0] head_inst,
    output logic [ADDR_W-1:0] head_pc,
    output logic [1:0]        state,
    output logic              if_ready
);

    idq_state_e state_q, state_d;
    logic       if_ready_q, if_ready_d;

    logic [1:0][INST_W-1:0] inst_q, inst_d;
    logic [1:0][ADDR_W-1:0] pc_q, pc_d;

    // ---- state register ----------------------------------------------------
    // if_ready resets to 1 so it is already high in the first cycle after rst;
    // the output gate below keeps it low while rst is asserted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDQ_EMPTY;
            if_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            if_ready_q <= if_ready_d;
        end
    end

    // ---- next-state logic --------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDQ_EMPTY;
        end else begin
            unique case (state_q)
                IDQ_EMPTY: if (push) state_d = IDQ_ONE;
                IDQ_ONE: begin
                    if (push && !pop)      state_d = IDQ_TWO;
                    else if (!push && pop) state_d = IDQ_EMPTY;
                end
                IDQ_TWO:   if (pop) state_d = IDQ_ONE;
                default:   state_d = IDQ_EMPTY;
            endcase
        end
        // Readiness is a pure function of the next occupancy, so a slot freed
        // by a pop is only offered to IF one cycle later.
        if_ready_d = (state_d != IDQ_TWO);
    end

    // ---- storage next values -----------------------------------------------
    // Flush leaves the stale payload in place; it is unobservable because the
    // queue is EMPTY and id_valid is low.
    always_comb begin
        inst_d = inst_q;
        pc_d   = pc_q;
        if (!flush) begin
            unique case (state_q)
                IDQ_EMPTY: begin
                    if (push) begin
                        inst_d[0] = in_inst;
                        pc_d[0]   = in_pc;
                    end
                end
                IDQ_ONE: begin
                    if (push && pop) begin
                        // head leaves, newcomer becomes head directly
                        inst_d[0] = in_inst;
                        pc_d[0]   = in_pc;
                    end else if (push) begin
                        inst_d[1] = in_inst;
                        pc_d[1]   = in_pc;
                    end
                end
                IDQ_TWO: begin
                    if (pop) begin
                        inst_d[0] = inst_q[1];
                        pc_d[0]   = pc_q[1];
                    end
                end
                default: ;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (rst) begin
                    inst_q[gi] <= '0;
                    pc_q[gi]   <= '0;
                end else begin
                    inst_q[gi] <= inst_d[gi];
                    pc_q[gi]   <= pc_d[gi];
                end
            end
        end
    endgenerate

    // ---- outputs -----------------------------------------------------------
    always_comb begin
        head_inst = inst_q[0];
        head_pc   = pc_q[0];
        state     = state_q;
        if_ready  = if_ready_q & ~rst;
    end

endmodule

// File: rtl/id_issue_ctrl.sv
// -----------------------------------------------------------------------------
// id_issue_ctrl
// Decode-stage sequencer: buffers fetched instructions in a 2-entry skid queue,
// presents the head to the combinational decoder and issues it to EX. A load in
// EX whose destination matches the head's reg_s/reg_t stalls issue for
// LOAD_USE_BUBBLE extra cycles. flush kills everything queued.
//
// Optional feature: define ID_PERF_CNT_EN to add the stall_cycles counter port
// (cycles with a head present that did not issue; cleared by rst only).
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   if_valid/if_inst/if_pc   IF offer
//   if_ready                 queue accepts (registered)
//   id_valid/id_inst/id_pc   head issuable / head contents
//   ex_ready                 EX accepts; issue = id_valid & ex_ready
//   dec_reg_s, dec_reg_t     decoder source registers of the head
//   ex_load_valid/ex_load_rt load currently in EX and its destination
//   flush                    pipeline redirect
//   stall_cycles             (ID_PERF_CNT_EN) stall counter, wraps at 2^32
// -----------------------------------------------------------------------------
module id_issue_ctrl
    import id_issue_ctrl_pkg::*;
#(
    parameter int INST_W          = 32,
    parameter int ADDR_W          = 32,
    parameter int LOAD_USE_BUBBLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [INST_W-1:0] if_inst,
    input  logic [ADDR_W-1:0] if_pc,
    output logic              if_ready,
    output logic              id_valid,
    output logic [INST_W-1:0] id_inst,
    output logic [ADDR_W-1:0] id_pc,
    input  logic              ex_ready,
    input  logic [4:0]        dec_reg_s,
    input  logic [4:0]        dec_reg_t,
    input  logic              ex_load_valid,
    input  logic [4:0]        ex_load_rt,
    input  logic              flush
`ifdef ID_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cycles
`endif
);

    localparam logic [1:0] BUBBLE_LOAD = 2'(LOAD_USE_BUBBLE);

    logic       push;
    logic       pop;
    logic       issue;
    logic       haz;
    logic       head_present;
    logic [1:0] q_state;
    logic [1:0] bub_cnt_q, bub_cnt_d;

    id_skid_buf #(
        .INST_W (INST_W),
        .ADDR_W (ADDR_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (flush),
        .in_inst   (if_inst),
        .in_pc     (if_pc),
        .head_inst (id_inst),
        .head_pc   (id_pc),
        .state     (q_state),
        .if_ready  (if_ready)
    );

    // ---- hazard detection and issue gating ---------------------------------
    // Hazard is only sampled while no bubble is pending, so a load still in EX
    // when the bubble runs out is re-checked on the following cycle.
    always_comb begin
        head_present = (q_state != IDQ_EMPTY);
        haz          = ex_load_valid
                     & (load_dep(ex_load_rt, dec_reg_s) | load_dep(ex_load_rt, dec_reg_t))
                     & head_present
                     & (bub_cnt_q == 2'd0);
        id_valid     = head_present & (bub_cnt_q == 2'd0) & ~haz & ~flush;
        issue        = id_valid & ex_ready;
        // id_valid already excludes flush, so a flush cycle never pops.
        pop          = issue;
        // Skid buffer gives flush priority, so a same-cycle IF beat is dropped.
        push         = if_valid & if_ready;
    end

    // ---- bubble counter ----------------------------------------------------
    always_comb begin
        bub_cnt_d = bub_cnt_q;
        if (flush)                  bub_cnt_d = 2'd0;
        else if (haz)               bub_cnt_d = BUBBLE_LOAD;
        else if (bub_cnt_q != 2'd0) bub_cnt_d = bub_cnt_q - 2'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) bub_cnt_q <= 2'd0;
        else     bub_cnt_q <= bub_cnt_d;
    end

`ifdef ID_PERF_CNT_EN
    // ---- stall performance counter -----------------------------------------
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (head_present && !issue && !flush) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) stall_cnt_q <= 32'd0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_id_issue_ctrl
// Directed stimulus with a scoreboard: every instruction expected to issue is
// queued when it is offered; the monitor pops and compares on each issue.
// -----------------------------------------------------------------------------
module tb_id_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        ex_ready;
    logic [4:0]  dec_reg_s;
    logic [4:0]  dec_reg_t;
    logic        ex_load_valid;
    logic [4:0]  ex_load_rt;
    logic        flush;
`ifdef ID_PERF_CNT_EN
    logic [31:0] stall_cycles;
`endif

    always #5 clk = ~clk;

    id_issue_ctrl #(
        .INST_W          (32),
        .ADDR_W          (32),
        .LOAD_USE_BUBBLE (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .if_valid      (if_valid),
        .if_inst       (if_inst),
        .if_pc         (if_pc),
        .if_ready      (if_ready),
        .id_valid      (id_valid),
        .id_inst       (id_inst),
        .id_pc         (id_pc),
        .ex_ready      (ex_ready),
        .dec_reg_s     (dec_reg_s),
        .dec_reg_t     (dec_reg_t),
        .ex_load_valid (ex_load_valid),
        .ex_load_rt    (ex_load_rt),
        .flush         (flush)
`ifdef ID_PERF_CNT_EN
        ,
        .stall_cycles  (stall_cycles)
`endif
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } txn_t;

    txn_t exp_q[$];
    txn_t mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end else begin
            $display("ok   %s value=%h", name, act);
        end
    endtask

    // ---- monitor: compare every issue against the scoreboard ---------------
    always @(negedge clk) begin
        if (rst === 1'b0 && id_valid === 1'b1 && ex_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue actual inst=%h pc=%h required=no issue",
                         id_inst, id_pc);
            end else begin
                mon_exp = exp_q.pop_front();
                check("issue_inst", id_inst, mon_exp.inst);
                check("issue_pc", id_pc, mon_exp.pc);
            end
        end
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] inst, input logic [31:0] pc, input bit expect_issue);
        if_valid = 1'b1;
        if_inst  = inst;
        if_pc    = pc;
        if (expect_issue) exp_q.push_back('{inst: inst, pc: pc});
    endtask

    // Push one instruction, hold a load hazard for detect + bubble, then release.
    task automatic run_hazard(input logic [4:0] rt, input logic [4:0] rs, input logic [4:0] rtt,
                              input logic [31:0] inst, input logic [31:0] pc);
        ex_ready      = 1'b1;
        ex_load_valid = 1'b1;
        ex_load_rt    = rt;
        dec_reg_s     = rs;
        dec_reg_t     = rtt;
        offer(inst, pc, 1'b1);
        next_cyc();
        if_valid = 1'b0;
        @(negedge clk); check("haz_detect_id_valid", 32'(id_valid), 32'd0);
        next_cyc();
        @(negedge clk); check("haz_bubble_id_valid", 32'(id_valid), 32'd0);
        next_cyc();
        ex_load_valid = 1'b0;
        @(negedge clk); check("haz_release_id_valid", 32'(id_valid), 32'd1);
        next_cyc();
        @(negedge clk); check("haz_after_empty", 32'(id_valid), 32'd0);
        dec_reg_s = 5'd0;
        dec_reg_t = 5'd0;
        ex_load_rt = 5'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        if_valid      = 1'b0;
        if_inst       = '0;
        if_pc         = '0;
        ex_ready      = 1'b0;
        dec_reg_s     = 5'd0;
        dec_reg_t     = 5'd0;
        ex_load_valid = 1'b0;
        ex_load_rt    = 5'd0;
        flush         = 1'b0;

        // ---- reset: 3 cycles --------------------------------------------------
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("rst_id_valid", 32'(id_valid), 32'd0);
        check("rst_if_ready", 32'(if_ready), 32'd0);
        check("rst_id_inst", id_inst, 32'd0);
        check("rst_id_pc", id_pc, 32'd0);
        next_cyc();
        rst = 1'b0;

        // ---- 1: single push, issue next cycle -----------------------------------
        ex_ready = 1'b1;
        offer(32'h24010005, 32'hBFC00000, 1'b1);
        @(negedge clk); check("post_rst_if_ready", 32'(if_ready), 32'd1);
        next_cyc();
        if_valid = 1'b0;
        @(negedge clk);
        check("t1_id_valid", 32'(id_valid), 32'd1);
        check("t1_id_inst", id_inst, 32'h24010005);
        check("t1_id_pc", id_pc, 32'hBFC00000);
        next_cyc();
        @(negedge clk); check("t1_empty_after_issue", 32'(id_valid), 32'd0);
        next_cyc();

        // ---- 2: back-to-back with EX stalled ---------------------------------
        ex_ready = 1'b0;
        offer(32'h00221820, 32'hBFC00004, 1'b1);
        @(negedge clk); check("t2_c0_if_ready", 32'(if_ready), 32'd1);
        next_cyc();
        offer(32'h00432022, 32'hBFC00008, 1'b1);
        @(negedge clk);
        check("t2_c1_if_ready", 32'(if_ready), 32'd1);
        check("t2_c1_id_valid", 32'(id_valid), 32'd1);
        next_cyc();
        offer(32'h8C450010, 32'hBFC0000C, 1'b1);
        @(negedge clk); check("t2_full_if_ready", 32'(if_ready), 32'd0);
        next_cyc();
        @(negedge clk);
        check("t2_full_if_ready2", 32'(if_ready), 32'd0);
        check("t2_head_held", id_inst, 32'h00221820);
        next_cyc();
        ex_ready = 1'b1;
        @(negedge clk); check("t2_pop_if_ready_still0", 32'(if_ready), 32'd0);
        next_cyc();
        @(negedge clk); check("t2_slot_free_if_ready", 32'(if_ready), 32'd1);
        next_cyc();
        if_valid = 1'b0;
        @(negedge clk); check("t2_third_head", id_inst, 32'h8C450010);
        next_cyc();
        @(negedge clk); check("t2_drained", 32'(id_valid), 32'd0);
        next_cyc();

        // ---- 3: load-use on reg_t, then on reg_s ---------------------------------
        run_hazard(5'd5, 5'd7, 5'd5, 32'h00A53021, 32'hBFC00010);
        next_cyc();
        run_hazard(5'd9, 5'd9, 5'd3, 32'h01233821, 32'hBFC00014);
        next_cyc();

        // ---- 4: load into r0 never stalls ----------------------------------------
        ex_ready      = 1'b1;
        ex_load_valid = 1'b1;
        ex_load_rt    = 5'd0;
        dec_reg_s     = 5'd0;
        dec_reg_t     = 5'd0;
        offer(32'h00004020, 32'hBFC00018, 1'b1);
        next_cyc();
        if_valid = 1'b0;
        @(negedge clk); check("t4_r0_no_bubble", 32'(id_valid), 32'd1);
        next_cyc();
        ex_load_valid = 1'b0;

        // ---- 5: flush a full queue with a same-cycle IF beat -------------------
        ex_ready = 1'b0;
        offer(32'h11111111, 32'hBFC00020, 1'b0);
        next_cyc();
        offer(32'h22222222, 32'hBFC00024, 1'b0);
        next_cyc();
        flush = 1'b1;
        offer(32'h33333333, 32'hBFC00028, 1'b0);
        @(negedge clk);
        check("t5_flush_id_valid", 32'(id_valid), 32'd0);
        check("t5_full_if_ready", 32'(if_ready), 32'd0);
        next_cyc();
        flush    = 1'b0;
        if_valid = 1'b0;
        ex_ready = 1'b1;
        @(negedge clk);
        check("t5_post_flush_id_valid", 32'(id_valid), 32'd0);
        check("t5_post_flush_if_ready", 32'(if_ready), 32'd1);
        next_cyc();
        @(negedge clk); check("t5_still_empty", 32'(id_valid), 32'd0);
        offer(32'h44444444, 32'hBFC00030, 1'b1);
        next_cyc();
        if_valid = 1'b0;
        @(negedge clk); check("t5_resume_inst", id_inst, 32'h44444444);
        next_cyc();

        // ---- 6: stall counter and mid-stream reset -----------------------------
        ex_ready = 1'b0;
        rst      = 1'b1;
        next_cyc();
        rst = 1'b0;
`ifdef ID_PERF_CNT_EN
        @(negedge clk); check("t6_stall_cleared", stall_cycles, 32'd0);
`endif
        offer(32'h55555555, 32'hBFC00040, 1'b0);
        next_cyc();
        if_valid = 1'b0;
        repeat (4) next_cyc();
        @(negedge clk);
        check("t6_head_present", 32'(id_valid), 32'd1);
`ifdef ID_PERF_CNT_EN
        check("t6_stall_4", stall_cycles, 32'd4);
`endif
        next_cyc();
        rst = 1'b1;
        @(negedge clk); check("t6_rst_if_ready", 32'(if_ready), 32'd0);
        next_cyc();
        rst = 1'b0;
        @(negedge clk);
        check("t6_post_rst_id_valid", 32'(id_valid), 32'd0);
        check("t6_post_rst_if_ready", 32'(if_ready), 32'd1);
`ifdef ID_PERF_CNT_EN
        check("t6_post_rst_stall", stall_cycles, 32'd0);
`endif
        ex_ready = 1'b1;
        next_cyc();
        next_cyc();

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
